ram_bus_master: RTL and testbench
=================================

Name: ram_bus_master

Overview:
- Bus initiator for the team's single-port synchronous RAM interface (shared addr, bidirectional data, cs/we/oe).
- Accepts single read/write requests from a CPU-side valid/ready port and sequences the RAM control lines.
- Owns bus turnaround: it never drives data while the RAM may be driving it.
- Sits between the datapath/load-store unit and the RAM instance.

Parameters:
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- WAIT_STATES, 0, extra cycles held in RD_ADDR before output enable; range 0..15.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  master can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse, for reads and writes.
- rsp_rdata  output  DATA_WIDTH  read data; valid when rsp_valid is high after a read.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_data  inout  DATA_WIDTH  RAM data bus.
- mem_cs  output  1  RAM chip select.
- mem_we  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - mem_cs, mem_we, mem_oe, rsp_valid all 0.
  - mem_addr=0, rsp_rdata=0, wait counter=0.
  - mem_data released to high-Z.
- Reset mid-operation aborts the access immediately with no response.
- All outputs are registered. mem_data drive enable is a registered flag, high only in state WR.
- States: IDLE, RD_ADDR, RD_DATA, RD_DONE, WR, WR_DONE.
- IDLE:
  - req_ready=1; no other state asserts req_ready.
  - Handshake completes on a posedge with req_valid&req_ready.
  - On handshake, latch req_addr to mem_addr and req_wdata to a write register; later request-side changes are ignored.
  - req_we=0 goes to RD_ADDR; req_we=1 goes to WR.
- RD_ADDR:
  - cs=1, we=0, oe=0; the RAM captures read data on its falling edge.
  - Stays 1+WAIT_STATES cycles (counter), then goes to RD_DATA.
- RD_DATA:
  - cs=1, we=0, oe=1; the RAM drives mem_data.
  - The posedge leaving this state samples mem_data into rsp_rdata.
  - Goes to RD_DONE.
- RD_DONE:
  - cs=0, oe=0; rsp_valid=1 for this cycle.
  - Acts as the turnaround cycle: neither side drives.
  - Goes to IDLE.
- WR:
  - cs=1, we=1, oe=0; master drives the write register onto mem_data.
  - The RAM writes on the posedge ending this cycle. Goes to WR_DONE.
- WR_DONE:
  - cs=0, we=0; bus high-Z; rsp_valid=1.
  - rsp_rdata holds its previous value. Goes to IDLE.
- Latency, counted from the handshake edge:
  - Read: rsp_valid is high in the 3rd cycle after handshake (plus WAIT_STATES).
  - Write: rsp_valid is high in the 2nd cycle.
  - Throughput: one read per 4+WAIT_STATES cycles; one write per 3 cycles.
- Invariant: master drive enable and (mem_cs&mem_oe&!mem_we) are never both high in the same cycle.
- rsp_valid is never high in two consecutive cycles.
- Address wrap is not applicable; addresses pass through unmodified.

Decomposition:
- Shared package ram_bus_pkg holds:
  - state enum typedef ram_bus_state_t;
  - localparam WAIT_CNT_W=4.
- No sub-module needed. The tri-state driver is one continuous assign inside the block.

Test Plan:
- Reset/idle: rst_n=0 then release, no requests → req_ready=1; cs/we/oe=0; mem_data high-Z; rsp_valid never asserts.
- Write then read: write addr 0x010 data 0xBEEF, then read 0x010 → write rsp_valid 2 cycles after handshake; read rsp_rdata=0xBEEF 3 cycles after handshake.
- Back-to-back: req_valid held high with writes 0x001=0x1111, 0x002=0x2222, then reads of both → each accepted only when req_ready=1; reads return 0x1111 and 0x2222; no bus contention (checker on the drive invariant).
- WAIT_STATES=3: read of preloaded 0x0FF=0x5A5A → RD_ADDR lasts 4 cycles; rsp_valid 6 cycles after handshake; data 0x5A5A.
- Reset mid-read: assert rst_n=0 during RD_DATA → outputs zero immediately; bus high-Z; no rsp_valid; a following read of 0x010 still returns 0xBEEF.
- Request stability: change req_addr/req_wdata in the cycle after handshake → access uses the latched values only.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types for the single-port RAM bus initiator.
// Holds the FSM state encoding and the wait-state counter width.
package ram_bus_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RD_DONE,
        ST_WR,
        ST_WR_DONE
    } ram_bus_state_t;

endpackage

// File: rtl/ram_bus_master.sv
// Sequences single read/write requests onto the shared RAM bus.
// Every output is a flop; the bus is only driven while in ST_WR.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

    ram_bus_state_t        state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  rsp_q, rsp_d;
    logic                  drv_en_q, drv_en_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = req_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_DATA: begin
                rdata_d = mem_data;
                state_d = ST_RD_DONE;
            end
            ST_RD_DONE: state_d = ST_IDLE;
            ST_WR:      state_d = ST_WR_DONE;
            ST_WR_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in a flop.
        ready_d  = (state_d == ST_IDLE);
        cs_d     = (state_d == ST_RD_ADDR) || (state_d == ST_RD_DATA)
                || (state_d == ST_WR);
        we_d     = (state_d == ST_WR);
        oe_d     = (state_d == ST_RD_DATA);
        rsp_d    = (state_d == ST_RD_DONE) || (state_d == ST_WR_DONE);
        drv_en_d = (state_d == ST_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b1;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            rsp_q    <= 1'b0;
            drv_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            rsp_q    <= rsp_d;
            drv_en_q <= drv_en_d;
        end
    end

    assign mem_data  = drv_en_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign req_ready = ready_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with behavioural RAMs.
// One instance with no wait states, one with three.
module tb_ram_bus_master;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, mem_cs, mem_we, mem_oe;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    logic          w_req_valid = 1'b0;
    logic          w_req_we = 1'b0;
    logic [AW-1:0] w_req_addr = '0;
    logic [DW-1:0] w_req_wdata = '0;
    logic          w_req_ready, w_rsp_valid, w_mem_cs, w_mem_we, w_mem_oe;
    logic [DW-1:0] w_rsp_rdata;
    logic [AW-1:0] w_mem_addr;
    wire  [DW-1:0] w_mem_data;

    ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
        .mem_addr(w_mem_addr), .mem_data(w_mem_data),
        .mem_cs(w_mem_cs), .mem_we(w_mem_we), .mem_oe(w_mem_oe)
    );

    // RAM models: read data captured on the falling edge, writes on posedge
    logic [DW-1:0] ram  [0:(1<<AW)-1];
    logic [DW-1:0] ram2 [0:(1<<AW)-1];
    logic [DW-1:0] ram_rd, ram2_rd;

    always @(negedge clk) if (mem_cs && !mem_we) ram_rd <= ram[mem_addr];
    always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_rd : 'z;

    always @(negedge clk) if (w_mem_cs && !w_mem_we) ram2_rd <= ram2[w_mem_addr];
    always @(posedge clk) begin
        if (!rst_n) ram2[12'h0FF] <= 16'h5A5A;
        else if (w_mem_cs && w_mem_we) ram2[w_mem_addr] <= w_mem_data;
    end
    assign w_mem_data = (w_mem_cs && w_mem_oe && !w_mem_we) ? ram2_rd : 'z;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int dbl = 0;
    int contention = 0;
    logic prev_rsp = 1'b0;
    logic [DW-1:0] rsp_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rsp = 1'b0;
        end else begin
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_log.push_back(rsp_rdata);
            end
            if (rsp_valid && prev_rsp) dbl++;
            prev_rsp = rsp_valid;
            if (dut.drv_en_q && mem_cs && mem_oe && !mem_we) contention++;
            if (dut3.drv_en_q && w_mem_cs && w_mem_oe && !w_mem_we) contention++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_lat,
                          input logic [DW-1:0] exp_rd, input string nm);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~d;
        chk({nm, ".addr"}, 32'(mem_addr), 32'(a));
        chk({nm, ".busy"}, 32'(req_ready), 32'd0);
        if (we) chk({nm, ".wbus"}, 32'(mem_data), 32'(d));
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[10];
    logic          bb_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] bb_addr [4] = '{12'h001, 12'h002, 12'h001, 12'h002};
    logic [DW-1:0] bb_wdata[4] = '{16'h1111, 16'h2222, 16'h0, 16'h0};
    int            bb_hs   [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        int rdcyc;
        int lat;

        vecs[0] = '{1'b1, 12'h010, 16'hBEEF, 2, 16'h0000};
        vecs[1] = '{1'b0, 12'h010, 16'h0000, 3, 16'hBEEF};
        vecs[2] = '{1'b1, 12'hFFF, 16'hA5A5, 2, 16'hBEEF};
        vecs[3] = '{1'b1, 12'h000, 16'h0001, 2, 16'hBEEF};
        vecs[4] = '{1'b0, 12'hFFF, 16'h0000, 3, 16'hA5A5};
        vecs[5] = '{1'b0, 12'h000, 16'h0000, 3, 16'h0001};
        vecs[6] = '{1'b1, 12'hFDF, 16'h0BAD, 2, 16'h0001};
        vecs[7] = '{1'b0, 12'hFDF, 16'h0000, 3, 16'h0BAD};
        vecs[8] = '{1'b1, 12'h7FF, 16'hFFFF, 2, 16'h0BAD};
        vecs[9] = '{1'b0, 12'h7FF, 16'h0000, 3, 16'hFFFF};

        // reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.cs", 32'(mem_cs), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle.ready", 32'(req_ready), 32'd1);
        chk("idle.ctl", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
        chk("idle.addr", 32'(mem_addr), 32'd0);
        chk("idle.rdata", 32'(rsp_rdata), 32'd0);
        chk("idle.drv", 32'(dut.drv_en_q), 32'd0);
        chk("idle.rsp", 32'(rsp_cnt), 32'd0);

        // table-driven single accesses
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].lat, vecs[i].rdata, $sformatf("vec%0d", i));
        end

        // request stability: do_req scrambles inputs after the handshake
        do_req(1'b1, 12'h020, 16'h1234, 2, 16'hFFFF, "stab.wr");
        do_req(1'b0, 12'h020, 16'h0000, 3, 16'h1234, "stab.rd");
        do_req(1'b0, 12'hFDF, 16'h0000, 3, 16'h0BAD, "stab.other");

        // back-to-back with req_valid held high
        rsp_log.delete();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_we    = bb_we[i];
            req_addr  = bb_addr[i];
            req_wdata = bb_wdata[i];
            n = 0;
            while (!req_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk($sformatf("bb%0d.ready", i), 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            bb_hs[i] = cyc;
            chk($sformatf("bb%0d.taken", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bb.gap0", 32'(bb_hs[1] - bb_hs[0]), 32'd3);
        chk("bb.gap1", 32'(bb_hs[2] - bb_hs[1]), 32'd3);
        chk("bb.gap2", 32'(bb_hs[3] - bb_hs[2]), 32'd4);
        chk("bb.nrsp", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() == 4) begin
            chk("bb.rd1", 32'(rsp_log[2]), 32'h1111);
            chk("bb.rd2", 32'(rsp_log[3]), 32'h2222);
        end

        // three wait states
        w_req_valid = 1'b1;
        w_req_we    = 1'b0;
        w_req_addr  = 12'h0FF;
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        rdcyc = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (w_mem_cs && !w_mem_oe && !w_mem_we) rdcyc++;
            if (w_rsp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("ws3.rdaddr", 32'(rdcyc), 32'd4);
        chk("ws3.lat", 32'(lat), 32'd6);
        chk("ws3.rdata", 32'(w_rsp_rdata), 32'h5A5A);

        // reset in the middle of a read
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_oe && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("mid.inrd", 32'(mem_oe), 32'd1);
        c0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid.ctl", 32'({mem_cs, mem_we, mem_oe, rsp_valid}), 32'd0);
        chk("mid.ready", 32'(req_ready), 32'd1);
        chk("mid.addr", 32'(mem_addr), 32'd0);
        chk("mid.drv", 32'(dut.drv_en_q), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid.norsp", 32'(rsp_cnt), 32'(c0));
        do_req(1'b0, 12'h010, 16'h0000, 3, 16'hBEEF, "mid.after");

        chk("inv.contention", 32'(contention), 32'd0);
        chk("inv.dblrsp", 32'(dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
